// File: rtl/vx_acc_cmd_arb_if.sv
// Bundle of requester-side and accelerator-side signals for vx_acc_cmd_arb.
// master = arbiter view, slave = the cores/accelerator environment view.
interface vx_acc_cmd_arb_if #(
  parameter int NUM_REQS = 4,
  parameter int REQ_BITS = $clog2(NUM_REQS)
);
  // Handshake: acc_cmd_valid/data/src stay stable from assertion until the
  // cycle where acc_cmd_valid & acc_cmd_ready are both high; the transfer
  // happens on that clock edge. req_wr_en has no backpressure. acc_done is a
  // one-cycle pulse, with acc_status valid in that same cycle.
  logic [NUM_REQS-1:0]    req_wr_en;
  logic [NUM_REQS*32-1:0] req_wr_data;
  logic [NUM_REQS*32-1:0] req_rd_data;
  logic                   acc_cmd_valid;
  logic [31:0]            acc_cmd_data;
  logic [REQ_BITS-1:0]    acc_cmd_src;
  logic                   acc_cmd_ready;
  logic                   acc_done;
  logic [27:0]            acc_status;
  logic [NUM_REQS-1:0]    overflow;

  modport master (
    input  req_wr_en, req_wr_data, acc_cmd_ready, acc_done, acc_status,
    output req_rd_data, acc_cmd_valid, acc_cmd_data, acc_cmd_src, overflow
  );

  modport slave (
    output req_wr_en, req_wr_data, acc_cmd_ready, acc_done, acc_status,
    input  req_rd_data, acc_cmd_valid, acc_cmd_data, acc_cmd_src, overflow
  );
endinterface

// File: rtl/vx_acc_cmd_arb.sv
// Round-robin arbiter sharing one accelerator command port among NUM_REQS units.
// Optional WAIT watchdog is enabled by defining ACC_ARB_TIMEOUT_EN.
module vx_acc_cmd_arb #(
  parameter int NUM_REQS       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_acc_cmd_arb_if.master     arb_if,
  output logic [1:0]           state_o
);
  localparam int REQ_BITS = $clog2(NUM_REQS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_REQS-1:0]    pending_q, pending_d;
  logic [NUM_REQS-1:0]    overflow_q, overflow_d;
  logic [NUM_REQS-1:0]    capture;
  logic [31:0]            cmd_buf_q [NUM_REQS];
  logic [27:0]            status_q [NUM_REQS];
  logic [REQ_BITS-1:0]    rr_ptr_q;
  logic                   cmd_valid_q;
  logic [31:0]            cmd_data_q;
  logic [REQ_BITS-1:0]    cmd_src_q;
  logic [NUM_REQS*32-1:0] rd_data_q;
  logic [NUM_REQS-1:0]    to_flag;

  logic                   win_found;
  logic [REQ_BITS-1:0]    win_idx;
  int                     rr_idx;
  logic                   grant;
  logic [NUM_REQS-1:0]    grant_vec;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % NUM_REQS;
      if (!win_found && pending_q[rr_idx[REQ_BITS-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_idx[REQ_BITS-1:0];
      end
    end
  end

  assign grant     = (state_q == ST_IDLE) && win_found;
  assign grant_vec = grant ? (NUM_REQS'(1) << win_idx) : '0;

  // A pulse arriving in the same cycle its slot is granted refills the slot.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    capture    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (arb_if.req_wr_en[i] && (!pending_q[i] || grant_vec[i])) begin
        pending_d[i] = 1'b1;
        capture[i]   = 1'b1;
      end else if (arb_if.req_wr_en[i]) begin
        overflow_d[i] = 1'b1;
      end else if (grant_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (capture[i]) cmd_buf_q[i] <= arb_if.req_wr_data[i*32 +: 32];
    end
  end

`ifdef ACC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [NUM_REQS-1:0] timeout_q;
  assign to_flag = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_flag = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_src_q   <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < NUM_REQS; i++) status_q[i] <= '0;
`ifdef ACC_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= cmd_buf_q[win_idx];
            cmd_src_q   <= win_idx;
            rr_ptr_q    <= (win_idx == REQ_BITS'(NUM_REQS - 1)) ? '0 : win_idx + 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (arb_if.acc_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
`ifdef ACC_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (arb_if.acc_done) begin
            status_q[cmd_src_q] <= arb_if.acc_status;
            state_q             <= ST_IDLE;
`ifdef ACC_ARB_TIMEOUT_EN
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q[cmd_src_q] <= 1'b1;
            status_q[cmd_src_q]  <= 28'hFFFFFFF;
            state_q              <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        rd_data_q[i*32 +: 32] <= {pending_q[i],
                                  (state_q != ST_IDLE) && (cmd_src_q == REQ_BITS'(i)),
                                  overflow_q[i], to_flag[i], status_q[i]};
      end
    end
  end

  assign arb_if.acc_cmd_valid = cmd_valid_q;
  assign arb_if.acc_cmd_data  = cmd_data_q;
  assign arb_if.acc_cmd_src   = cmd_src_q;
  assign arb_if.req_rd_data   = rd_data_q;
  assign arb_if.overflow      = overflow_q;
  assign state_o              = state_q;
endmodule

// File: tb/tb_vx_acc_cmd_arb.sv
// Scoreboard bench for vx_acc_cmd_arb: directed requests push expected
// commands; a negedge monitor pops them on every accepted command.
module tb_vx_acc_cmd_arb;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_o;

  vx_acc_cmd_arb_if #(.NUM_REQS(N)) bus_if ();

  vx_acc_cmd_arb #(.NUM_REQS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .arb_if  (bus_if),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every accepted command must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus_if.acc_cmd_valid === 1'b1 && bus_if.acc_cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL cmd_unexpected: got src %0d data 0x%08h, expected no command",
                 bus_if.acc_cmd_src, bus_if.acc_cmd_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("cmd_src", 32'(bus_if.acc_cmd_src), 32'(e[33:32]));
        check("cmd_data", bus_if.acc_cmd_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int src, input logic [31:0] data);
    logic [1:0] s;
    s = src[1:0];
    exp_q.push_back({s, data});
  endtask

  task automatic pulse(input int i, input logic [31:0] d);
    bus_if.req_wr_en = '0;
    bus_if.req_wr_en[i] = 1'b1;
    bus_if.req_wr_data[i*32 +: 32] = d;
    tick();
    bus_if.req_wr_en = '0;
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int n;
    n = 0;
    while (state_o !== st && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(state_o), 32'(st));
  endtask

  task automatic finish_cmd(input logic [27:0] st);
    wait_state(S_WAIT, "wait_entry");
    bus_if.acc_done   = 1'b1;
    bus_if.acc_status = st;
    tick();
    bus_if.acc_done   = 1'b0;
    bus_if.acc_status = '0;
  endtask

  function automatic logic [31:0] rd(input int i);
    return bus_if.req_rd_data[i*32 +: 32];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus_if.req_wr_en     = '0;
    bus_if.req_wr_data   = '0;
    bus_if.acc_cmd_ready = 1'b0;
    bus_if.acc_done      = 1'b0;
    bus_if.acc_status    = '0;
    repeat (3) tick();
    check("rst_valid", 32'(bus_if.acc_cmd_valid), 32'd0);
    check("rst_data", bus_if.acc_cmd_data, 32'd0);
    check("rst_src", 32'(bus_if.acc_cmd_src), 32'd0);
    check("rst_overflow", 32'(bus_if.overflow), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    for (int i = 0; i < N; i++) check("rst_rd", rd(i), 32'd0);
    reset = 1'b0;
    bus_if.acc_cmd_ready = 1'b1;
    tick();

    // Single command: valid appears two cycles after the pulse.
    expect_cmd(1, 32'h12345678);
    pulse(1, 32'h12345678);
    check("t1_valid_early", 32'(bus_if.acc_cmd_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus_if.acc_cmd_valid), 32'd1);
    check("t1_src", 32'(bus_if.acc_cmd_src), 32'd1);
    tick();
    check("t1_rd_busy", rd(1), 32'h40000000);
    finish_cmd(28'hA5);
    tick();
    check("t1_rd_status", rd(1), 32'h000000A5);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Round robin from pointer 0, then req2+req0 together.
    for (int i = 0; i < N; i++) expect_cmd(i, 32'h100 + i);
    bus_if.req_wr_en = 4'hF;
    for (int i = 0; i < N; i++) bus_if.req_wr_data[i*32 +: 32] = 32'h100 + i;
    tick();
    bus_if.req_wr_en = '0;
    for (int k = 0; k < N; k++) finish_cmd(28'h10 + 28'(k));
    expect_cmd(0, 32'h200);
    expect_cmd(2, 32'h202);
    bus_if.req_wr_en = 4'b0101;
    bus_if.req_wr_data[0 +: 32]  = 32'h200;
    bus_if.req_wr_data[64 +: 32] = 32'h202;
    tick();
    bus_if.req_wr_en = '0;
    finish_cmd(28'h20);
    finish_cmd(28'h22);
    tick();
    tick();
    check("t2_rd0", rd(0), 32'h00000020);
    check("t2_rd1", rd(1), 32'h00000011);
    check("t2_rd2", rd(2), 32'h00000022);
    check("t2_rd3", rd(3), 32'h00000013);

    // Backpressure: command held stable while ready is low.
    bus_if.acc_cmd_ready = 1'b0;
    expect_cmd(3, 32'hDEADBEEF);
    pulse(3, 32'hDEADBEEF);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 32'(bus_if.acc_cmd_valid), 32'd1);
      check("t3_hold_data", bus_if.acc_cmd_data, 32'hDEADBEEF);
      check("t3_hold_src", 32'(bus_if.acc_cmd_src), 32'd3);
      check("t3_hold_state", 32'(state_o), 32'(S_ISSUE));
      tick();
    end
    bus_if.acc_cmd_ready = 1'b1;
    tick();
    check("t3_accept_state", 32'(state_o), 32'(S_WAIT));
    check("t3_accept_valid", 32'(bus_if.acc_cmd_valid), 32'd0);
    finish_cmd(28'h33);

    // Overflow: second pulse to a full slot is dropped.
    expect_cmd(0, 32'hAAAA0000);
    pulse(0, 32'hAAAA0000);
    wait_state(S_WAIT, "t4_wait");
    expect_cmd(2, 32'h1);
    pulse(2, 32'h1);
    pulse(2, 32'h2);
    tick();
    check("t4_overflow", 32'(bus_if.overflow), 32'h4);
    check("t4_rd2", rd(2), 32'hA0000022);
    finish_cmd(28'h40);
    finish_cmd(28'h42);

    // Pulse in the same cycle as its own grant refills without overflow.
    expect_cmd(1, 32'h0B0B0001);
    expect_cmd(1, 32'h0B0B0002);
    pulse(1, 32'h0B0B0001);
    pulse(1, 32'h0B0B0002);
    finish_cmd(28'h50);
    finish_cmd(28'h51);
    tick();
    tick();
    check("t4b_overflow", 32'(bus_if.overflow), 32'h4);
    check("t4b_rd1", rd(1), 32'h00000051);

    // Reset while waiting for done.
    expect_cmd(3, 32'h66666666);
    pulse(3, 32'h66666666);
    wait_state(S_WAIT, "t6_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid", 32'(bus_if.acc_cmd_valid), 32'd0);
    check("t6_state", 32'(state_o), 32'(S_IDLE));
    check("t6_overflow", 32'(bus_if.overflow), 32'd0);
    check("t6_rd3", rd(3), 32'd0);
    bus_if.acc_done   = 1'b1;
    bus_if.acc_status = 28'h99;
    tick();
    bus_if.acc_done   = 1'b0;
    bus_if.acc_status = '0;
    tick();
    check("t6_late_done_state", 32'(state_o), 32'(S_IDLE));
    check("t6_late_done_rd3", rd(3), 32'd0);
    expect_cmd(3, 32'h33333333);
    pulse(3, 32'h33333333);
    finish_cmd(28'h77);
    tick();
    check("t6_fresh_rd3", rd(3), 32'h00000077);

`ifdef ACC_ARB_TIMEOUT_EN
    begin
      int n;
      expect_cmd(0, 32'h70);
      expect_cmd(1, 32'h71);
      bus_if.req_wr_en = 4'b0011;
      bus_if.req_wr_data[0 +: 32]  = 32'h70;
      bus_if.req_wr_data[32 +: 32] = 32'h71;
      tick();
      bus_if.req_wr_en = '0;
      wait_state(S_WAIT, "t5_wait");
      n = 0;
      while (state_o == S_WAIT && n < 100) begin
        n++;
        tick();
      end
      check("t5_wait_cycles", 32'(n), 32'(TO));
      tick();
      check("t5_rd0", rd(0), 32'h1FFFFFFF);
      finish_cmd(28'h81);
      tick();
      check("t5_rd1", rd(1), 32'h00000081);
    end
`endif

    repeat (4) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
